// File: rtl/turn_lights_decoder.sv
// -----------------------------------------------------------------------------
// turn_lights_decoder
//
// Passive monitor for the 8-bit turn-light LED bus. It recovers the request
// behind the pattern on the bus (left, right or hazard) and the sequence
// phase. It checks every observed change against the controller's legal
// sequence and keeps saturating counts of completed sequences and errors.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   step         one-cycle strobe: the bus carries a new pattern this cycle
//   led[0:7]     observed LED bus, led[0] is the leftmost lamp
//   clr          synchronous clear of the counters and err_sticky
//   dir          00 none, 01 left, 10 right, 11 hazard
//   phase        0 idle, 1..4 lamps lit on the active side (4 for hazard)
//   left_done    one-cycle pulse: a left sequence completed
//   right_done   one-cycle pulse: a right sequence completed
//   hazard_done  one-cycle pulse: a hazard flash completed
//   err_pulse    one-cycle pulse on any detected error
//   err_sticky   set on error, cleared only by clr or reset
//   err_code     most recent error: 01 illegal pattern,
//                10 illegal transition, 11 glitch
//   left_cnt, right_cnt, hazard_cnt, err_cnt
//                saturating event counters, CNT_W bits each
// -----------------------------------------------------------------------------
module turn_lights_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic [0:7]       led,
   input  logic             clr,
   output logic [1:0]       dir,
   output logic [2:0]       phase,
   output logic             left_done,
   output logic             right_done,
   output logic             hazard_done,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] left_cnt,
   output logic [CNT_W-1:0] right_cnt,
   output logic [CNT_W-1:0] hazard_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // The state values are deliberately the same as the index of the matching
   // pattern in PAT. A pattern hit can then be turned into a resync target
   // directly.
   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_L1   = 4'd1,
      S_L2   = 4'd2,
      S_L3   = 4'd3,
      S_L4   = 4'd4,
      S_R1   = 4'd5,
      S_R2   = 4'd6,
      S_R3   = 4'd7,
      S_R4   = 4'd8,
      S_H    = 4'd9
   } state_t;

   localparam int NPAT = 10;
   localparam int NEVT = 4;   // event index: 0 left, 1 right, 2 hazard, 3 error

   // Legal bus patterns, written led[0]..led[7].
   localparam logic [0:7] PAT [NPAT] = '{
      8'b00000000,   // IDLE
      8'b00010000,   // L1
      8'b00110000,   // L2
      8'b01110000,   // L3
      8'b11110000,   // L4
      8'b00001000,   // R1
      8'b00001100,   // R2
      8'b00001110,   // R3
      8'b00001111,   // R4
      8'b11111111    // LR4 (hazard)
   };

   state_t           state_q, state_d;
   logic [0:7]       last_led_q;

   logic [NPAT-1:0]  pat_hit;
   logic             pat_legal;
   state_t           pat_state;

   logic             err_det;
   logic [1:0]       err_code_d;
   logic [NEVT-1:0]  evt;

   logic [1:0]       dir_q;
   logic [2:0]       phase_q;
   logic             left_done_q, right_done_q, hazard_done_q;
   logic             err_pulse_q, err_sticky_q;
   logic [1:0]       err_code_q;

   logic [CNT_W-1:0] cnt_val [NEVT];

   // ------------------------------------------------------------------
   // Pattern recognition
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NPAT; gi++) begin : g_match
      assign pat_hit[gi] = (led == PAT[gi]);
   end

   always_comb begin
      pat_legal = |pat_hit;
      pat_state = S_IDLE;
      for (int i = 0; i < NPAT; i++) begin
         if (pat_hit[i]) begin
            pat_state = state_t'(i[3:0]);
         end
      end
   end

   // Is `nxt` the controller's legal successor of `cur`?
   function automatic logic succ_ok(input state_t cur, input state_t nxt);
      logic ok;
      ok = 1'b0;
      case (cur)
         S_IDLE:            ok = (nxt == S_IDLE) || (nxt == S_L1) ||
                                 (nxt == S_R1)   || (nxt == S_H);
         S_L1:              ok = (nxt == S_L2);
         S_L2:              ok = (nxt == S_L3);
         S_L3:              ok = (nxt == S_L4);
         S_R1:              ok = (nxt == S_R2);
         S_R2:              ok = (nxt == S_R3);
         S_R3:              ok = (nxt == S_R4);
         S_L4, S_R4, S_H:   ok = (nxt == S_IDLE);
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [1:0] dir_of(input state_t s);
      logic [1:0] d;
      d = 2'b00;
      case (s)
         S_L1, S_L2, S_L3, S_L4: d = 2'b01;
         S_R1, S_R2, S_R3, S_R4: d = 2'b10;
         S_H:                    d = 2'b11;
         default:                d = 2'b00;
      endcase
      return d;
   endfunction

   function automatic logic [2:0] phase_of(input state_t s);
      logic [2:0] p;
      p = 3'd0;
      case (s)
         S_L1, S_R1:        p = 3'd1;
         S_L2, S_R2:        p = 3'd2;
         S_L3, S_R3:        p = 3'd3;
         S_L4, S_R4, S_H:   p = 3'd4;
         default:           p = 3'd0;
      endcase
      return p;
   endfunction

   // ------------------------------------------------------------------
   // Next state, error classification and completion events
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      err_det    = 1'b0;
      err_code_d = err_code_q;
      evt        = '0;

      if (step) begin
         if (!pat_legal) begin
            state_d    = S_IDLE;
            err_det    = 1'b1;
            err_code_d = 2'b01;
         end else begin
            // A legal but unexpected pattern still resyncs to whatever
            // the bus shows. This lets the monitor lock back on quickly
            // after a skipped step or a reset mid-sequence.
            state_d = pat_state;
            if (succ_ok(state_q, pat_state)) begin
               if (pat_state == S_IDLE) begin
                  evt[0] = (state_q == S_L4);
                  evt[1] = (state_q == S_R4);
                  evt[2] = (state_q == S_H);
               end
            end else begin
               err_det    = 1'b1;
               err_code_d = 2'b10;
            end
         end
      end else if (led != last_led_q) begin
         // The bus may only change on a step cycle.
         err_det    = 1'b1;
         err_code_d = 2'b11;
      end

      evt[3] = err_det;
   end

   // ------------------------------------------------------------------
   // Saturating event counters (clr beats a coincident increment)
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NEVT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (clr) begin
            cnt_d = '0;
         end else if (evt[gi] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_val[gi] = cnt_q;
   end

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         last_led_q    <= '0;
         dir_q         <= 2'b00;
         phase_q       <= 3'd0;
         left_done_q   <= 1'b0;
         right_done_q  <= 1'b0;
         hazard_done_q <= 1'b0;
         err_pulse_q   <= 1'b0;
         err_sticky_q  <= 1'b0;
         err_code_q    <= 2'b00;
      end else begin
         state_q       <= state_d;
         last_led_q    <= led;
         dir_q         <= dir_of(state_d);
         phase_q       <= phase_of(state_d);
         left_done_q   <= evt[0];
         right_done_q  <= evt[1];
         hazard_done_q <= evt[2];
         err_pulse_q   <= err_det;
         err_code_q    <= err_code_d;
         // A new error beats a coincident clr, so the sticky flag still
         // shows that it happened.
         if (err_det) begin
            err_sticky_q <= 1'b1;
         end else if (clr) begin
            err_sticky_q <= 1'b0;
         end
      end
   end

   assign dir         = dir_q;
   assign phase       = phase_q;
   assign left_done   = left_done_q;
   assign right_done  = right_done_q;
   assign hazard_done = hazard_done_q;
   assign err_pulse   = err_pulse_q;
   assign err_sticky  = err_sticky_q;
   assign err_code    = err_code_q;
   assign left_cnt    = cnt_val[0];
   assign right_cnt   = cnt_val[1];
   assign hazard_cnt  = cnt_val[2];
   assign err_cnt     = cnt_val[3];

endmodule

// File: tb/tb_turn_lights_decoder.sv
// -----------------------------------------------------------------------------
// tb_turn_lights_decoder
//
// Scoreboard bench for turn_lights_decoder. The stimulus process drives one
// bus cycle at each falling edge. For each cycle it asks a behavioural model
// for the expected response and queues that response. A separate monitor
// pops one entry after every rising edge and compares it with the DUT.
//
// The model does not hold a table of patterns or states. It classifies a
// bus value by counting the lit lamps on each half and checking that they
// grow contiguously from the centre.
// -----------------------------------------------------------------------------
module tb_turn_lights_decoder;

   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic             step;
   logic [0:7]       led;
   logic             clr;
   logic [1:0]       dir;
   logic [2:0]       phase;
   logic             left_done, right_done, hazard_done;
   logic             err_pulse, err_sticky;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] left_cnt, right_cnt, hazard_cnt, err_cnt;

   turn_lights_decoder #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .step        (step),
      .led         (led),
      .clr         (clr),
      .dir         (dir),
      .phase       (phase),
      .left_done   (left_done),
      .right_done  (right_done),
      .hazard_done (hazard_done),
      .err_pulse   (err_pulse),
      .err_sticky  (err_sticky),
      .err_code    (err_code),
      .left_cnt    (left_cnt),
      .right_cnt   (right_cnt),
      .hazard_cnt  (hazard_cnt),
      .err_cnt     (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int dir;  int phase;
      int ld;   int rd;   int hd;
      int ep;   int es;   int ec;
      int lc;   int rc;   int hc;  int ecnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // ---------------- behavioural model state ----------------
   int         m_side;     // 0 none, 1 left, 2 right, 3 hazard
   int         m_n;        // lamps lit on the active side
   logic [0:7] m_last;
   int         m_code, m_sticky, m_lc, m_rc, m_hc, m_ec;

   // Pattern with n lamps lit outward from the centre on the given side.
   function automatic logic [0:7] pat(input int side, input int n);
      logic [0:7] v;
      v = '0;
      for (int i = 0; i < 4; i++)
         if ((side == 1 || side == 3) && i >= 4 - n) v[i] = 1'b1;
      for (int i = 4; i < 8; i++)
         if ((side == 2 || side == 3) && i < 4 + n) v[i] = 1'b1;
      return v;
   endfunction

   task automatic classify(input logic [0:7] v, output int side, output int n,
                           output bit legal);
      int nl, nr;
      bit lok, rok;
      nl = 0; nr = 0; lok = 1'b1; rok = 1'b1;
      for (int i = 0; i < 4; i++) if (v[i]) nl++;
      for (int i = 4; i < 8; i++) if (v[i]) nr++;
      for (int i = 0; i < 4; i++) if (v[i] != (i >= 4 - nl)) lok = 1'b0;
      for (int i = 4; i < 8; i++) if (v[i] != (i < 4 + nr)) rok = 1'b0;
      legal = lok && rok;
      side = 0; n = 0;
      if (legal) begin
         if (nl == 0 && nr == 0)      begin side = 0; n = 0;  end
         else if (nr == 0)            begin side = 1; n = nl; end
         else if (nl == 0)            begin side = 2; n = nr; end
         else if (nl == 4 && nr == 4) begin side = 3; n = 4;  end
         else                         legal = 1'b0;
      end
   endtask

   function automatic int sinc(input int c);
      return (c >= CMAX) ? CMAX : c + 1;
   endfunction

   task automatic model_reset();
      m_side = 0; m_n = 0; m_last = '0;
      m_code = 0; m_sticky = 0;
      m_lc = 0; m_rc = 0; m_hc = 0; m_ec = 0;
   endtask

   task automatic model_step(input logic st, input logic [0:7] v,
                             input logic cl, output exp_t e);
      int s, n;
      bit legal, ok, err, ld, rd, hd;
      err = 0; ld = 0; rd = 0; hd = 0; ok = 0;
      classify(v, s, n, legal);
      if (st) begin
         if (!legal) begin
            err = 1; m_code = 1; m_side = 0; m_n = 0;
         end else begin
            if (m_side == 0)   ok = (s == 0) || (s == 3) || ((s == 1 || s == 2) && n == 1);
            else if (m_n == 4) ok = (s == 0);
            else               ok = (s == m_side) && (n == m_n + 1);
            if (ok && s == 0) begin
               ld = (m_side == 1); rd = (m_side == 2); hd = (m_side == 3);
            end
            if (!ok) begin err = 1; m_code = 2; end
            m_side = s; m_n = n;
         end
      end else if (v != m_last) begin
         err = 1; m_code = 3;
      end
      m_last = v;
      m_lc = cl ? 0 : (ld  ? sinc(m_lc) : m_lc);
      m_rc = cl ? 0 : (rd  ? sinc(m_rc) : m_rc);
      m_hc = cl ? 0 : (hd  ? sinc(m_hc) : m_hc);
      m_ec = cl ? 0 : (err ? sinc(m_ec) : m_ec);
      m_sticky = err ? 1 : (cl ? 0 : m_sticky);
      e.dir = m_side; e.phase = m_n;
      e.ld = int'(ld); e.rd = int'(rd); e.hd = int'(hd);
      e.ep = int'(err); e.es = m_sticky; e.ec = m_code;
      e.lc = m_lc; e.rc = m_rc; e.hc = m_hc; e.ecnt = m_ec;
   endtask

   // ---------------- comparison ----------------
   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic cmp_all(input exp_t e);
      chk("dir",         int'(dir),         e.dir);
      chk("phase",       int'(phase),       e.phase);
      chk("left_done",   int'(left_done),   e.ld);
      chk("right_done",  int'(right_done),  e.rd);
      chk("hazard_done", int'(hazard_done), e.hd);
      chk("err_pulse",   int'(err_pulse),   e.ep);
      chk("err_sticky",  int'(err_sticky),  e.es);
      chk("err_code",    int'(err_code),    e.ec);
      chk("left_cnt",    int'(left_cnt),    e.lc);
      chk("right_cnt",   int'(right_cnt),   e.rc);
      chk("hazard_cnt",  int'(hazard_cnt),  e.hc);
      chk("err_cnt",     int'(err_cnt),     e.ecnt);
      $display("cycle t=%0t dir=%0d phase=%0d done=%0d%0d%0d err=%0d/%0d code=%0d cnt=%0d,%0d,%0d,%0d",
               $time, dir, phase, left_done, right_done, hazard_done, err_pulse,
               err_sticky, err_code, left_cnt, right_cnt, hazard_cnt, err_cnt);
   endtask

   // Monitor: one expected response per rising edge that had stimulus.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp_all(e);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at a falling edge. It returns at the next falling edge.
   task automatic cycle(input logic st, input logic [0:7] v, input logic cl);
      exp_t e;
      step = st; led = v; clr = cl;
      model_step(st, v, cl, e);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic drive_step(input logic [0:7] v);
      cycle(1'b1, v, 1'b0);
   endtask

   task automatic hold();
      cycle(1'b0, led, 1'b0);
   endtask

   task automatic left_seq();
      for (int n = 1; n <= 4; n++) drive_step(pat(1, n));
      drive_step(pat(0, 0));
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin : watchdog
      #10_000_000;
      n_bad++;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      summary();
      $fatal(1, "timeout");
   end

   // ---------------- main stimulus ----------------
   initial begin : stim
      exp_t       zero;
      logic [0:7] v;
      logic       st, cl;
      int         r, c;

      zero = '{default: 0};
      reset = 1'b0; step = 1'b0; led = '0; clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      cmp_all(zero);
      reset = 1'b1;

      // Left chain
      left_seq();
      hold();

      // Hazard, then right chain
      drive_step(pat(3, 4));
      drive_step(pat(0, 0));
      for (int n = 1; n <= 4; n++) drive_step(pat(2, n));
      drive_step(pat(0, 0));
      hold();

      // Illegal pattern from idle, then a clean L1
      drive_step(8'b10100000);
      drive_step(pat(1, 1));
      // Skip L2: L3 is an illegal transition; L4, IDLE then complete cleanly
      drive_step(pat(1, 3));
      drive_step(pat(1, 4));
      drive_step(pat(0, 0));
      // Glitch: bus changes without step; then holds steady
      cycle(1'b0, 8'b00000100, 1'b0);
      hold();

      // Saturation of left_cnt
      for (int k = 0; k < 260; k++) left_seq();
      hold();
      // clr coinciding with a glitch
      cycle(1'b0, 8'b00000001, 1'b1);
      hold();

      // Reset during R2: outputs must clear without a clock edge
      drive_step(pat(2, 1));
      drive_step(pat(2, 2));
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      cmp_all(zero);
      @(negedge clk);
      reset = 1'b1;
      drive_step(pat(2, 3));
      drive_step(pat(2, 4));
      drive_step(pat(0, 0));

      // Randomised traffic
      for (int k = 0; k < 2000; k++) begin
         r  = $urandom_range(0, 99);
         cl = ($urandom_range(0, 99) < 3);
         if (r < 40) begin
            st = 1'b0; v = led;
         end else if (r < 85) begin
            st = 1'b1;
            if (m_side == 0) begin
               c = $urandom_range(0, 3);
               case (c)
                  0:       v = pat(0, 0);
                  1:       v = pat(1, 1);
                  2:       v = pat(2, 1);
                  default: v = pat(3, 4);
               endcase
            end else if (m_n == 4) begin
               v = pat(0, 0);
            end else begin
               v = pat(m_side, m_n + 1);
            end
         end else if (r < 92) begin
            st = 1'b1;
            c  = $urandom_range(0, 9);
            if (c == 0)      v = pat(0, 0);
            else if (c <= 4) v = pat(1, c);
            else if (c <= 8) v = pat(2, c - 4);
            else             v = pat(3, 4);
         end else if (r < 96) begin
            st = 1'b1; v = 8'($urandom);
         end else begin
            st = 1'b0; v = 8'($urandom);
         end
         cycle(st, v, cl);
      end

      step = 1'b0; clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      summary();
      $finish;
   end

endmodule
